// File: rtl/sd_pkg.sv
// Shared state codes and width helpers for the multi-channel state detector.
package sd_pkg;

    // Committed/candidate state codes, in decode priority order.
    localparam logic [1:0] ST_ON   = 2'b00;
    localparam logic [1:0] ST_OFF  = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;
    localparam logic [1:0] ST_OPEN = 2'b11;

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int unsigned sd_cnt_w(input int unsigned depth);
        return int'($clog2(depth + 1));
    endfunction

    // Width of an index over n items; never narrower than one bit.
    function automatic int unsigned sd_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage : sd_pkg

// File: rtl/sd_chan_filter.sv
// One channel: priority decode of the result strobes, persistence filter and
// commit of the filtered state. change_c/state_nxt_c describe the commit that
// happens on the coming edge so the top can track pending events in lockstep.
module sd_chan_filter
    import sd_pkg::*;
#(
    parameter int unsigned FILT_DEPTH = 8,
    parameter int unsigned CNT_W      = sd_cnt_w(FILT_DEPTH)
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       result_on,
    input  logic       result_off,
    input  logic       result_err,
    input  logic       result_open,
    output logic [1:0] state,
    output logic       state_valid,
    output logic       change_c,
    output logic [1:0] state_nxt_c
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FILT_DEPTH);

    logic             sample_vld;
    logic [1:0]       sample;
    logic [1:0]       cand_q;
    logic [1:0]       cand_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             commit;

    // Fixed-priority decode: on > off > err > open; nothing asserted = no sample.
    always_comb begin
        sample_vld = 1'b1;
        sample     = ST_ON;
        if (result_on) begin
            sample = ST_ON;
        end else if (result_off) begin
            sample = ST_OFF;
        end else if (result_err) begin
            sample = ST_ERR;
        end else if (result_open) begin
            sample = ST_OPEN;
        end else begin
            sample_vld = 1'b0;
        end
    end

    // Run-length filter on the candidate and commit decision for this edge.
    always_comb begin
        cand_nxt = cand_q;
        cnt_nxt  = cnt_q;
        if (!sample_vld) begin
            cnt_nxt = '0;
        end else if ((sample == cand_q) && (cnt_q != '0)) begin
            cnt_nxt = (cnt_q == DEPTH_C) ? DEPTH_C : cnt_q + CNT_W'(1);
        end else begin
            cand_nxt = sample;
            cnt_nxt  = CNT_W'(1);
        end
        // A saturated counter keeps re-committing the same state, which is silent.
        commit      = (cnt_nxt == DEPTH_C);
        change_c    = commit && (!state_valid || (cand_nxt != state));
        state_nxt_c = change_c ? cand_nxt : state;
    end

    // Candidate, counter and committed-state registers.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cand_q      <= '0;
            cnt_q       <= '0;
            state       <= '0;
            state_valid <= 1'b0;
        end else begin
            cand_q <= cand_nxt;
            cnt_q  <= cnt_nxt;
            state  <= state_nxt_c;
            if (change_c) begin
                state_valid <= 1'b1;
            end
        end
    end

endmodule : sd_chan_filter

// File: rtl/state_detect_multi.sv
// Multi-channel filtered state detector. Each channel commits a persistent
// state; committed changes are queued as one pending bit per channel and
// delivered lowest channel first over a valid/ready event port.
module state_detect_multi
    import sd_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned FILT_DEPTH = 8,
    localparam int unsigned CNT_W     = sd_cnt_w(FILT_DEPTH),
    localparam int unsigned CH_W      = sd_idx_w(N_CH)
) (
    input  logic                clk_50MHz,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     result_on,
    input  logic [N_CH-1:0]     result_off,
    input  logic [N_CH-1:0]     result_err,
    input  logic [N_CH-1:0]     result_open,
    output logic [2*N_CH-1:0]   state,
    output logic [N_CH-1:0]     state_valid,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CH_W-1:0]     evt_ch,
    output logic [1:0]          evt_state,
    output logic [N_CH-1:0]     overrun,
    input  logic                clr_overrun
);

    logic [N_CH-1:0] change_c;
    logic [1:0]      state_nxt_c [N_CH];
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] pend_nxt;
    logic [N_CH-1:0] overrun_nxt;
    logic            evt_acc_c;
    logic [CH_W-1:0] sel_ch_c;
    logic [CH_W-1:0] evt_ch_nxt;
    logic [1:0]      evt_state_nxt;

    // Per-channel decode/filter/commit.
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        sd_chan_filter #(
            .FILT_DEPTH (FILT_DEPTH),
            .CNT_W      (CNT_W)
        ) u_filt (
            .clk_50MHz   (clk_50MHz),
            .rst_n       (rst_n),
            .result_on   (result_on[g]),
            .result_off  (result_off[g]),
            .result_err  (result_err[g]),
            .result_open (result_open[g]),
            .state       (state[2*g +: 2]),
            .state_valid (state_valid[g]),
            .change_c    (change_c[g]),
            .state_nxt_c (state_nxt_c[g])
        );
    end

    // Pending and overrun updates; a new change beats a same-edge clear.
    always_comb begin
        evt_acc_c   = evt_valid & evt_ready;
        pend_nxt    = '0;
        overrun_nxt = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            pend_nxt[i]    = change_c[i] |
                             (pend_q[i] & ~(evt_acc_c && (evt_ch == CH_W'(i))));
            overrun_nxt[i] = (change_c[i] & pend_q[i]) | (overrun[i] & ~clr_overrun);
        end
    end

    // Lowest-index pending channel after this edge.
    always_comb begin
        sel_ch_c = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (pend_nxt[i]) begin
                sel_ch_c = CH_W'(i);
            end
        end
    end

    // A stalled event keeps its channel; its state always tracks the latest
    // commit of that channel, so an overrun delivers the newest value.
    always_comb begin
        evt_ch_nxt    = (evt_valid && !evt_ready) ? evt_ch : sel_ch_c;
        evt_state_nxt = state_nxt_c[evt_ch_nxt];
    end

    // Pending, overrun and event-port registers.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            overrun   <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_state <= '0;
        end else begin
            pend_q    <= pend_nxt;
            overrun   <= overrun_nxt;
            evt_valid <= |pend_nxt;
            evt_ch    <= evt_ch_nxt;
            evt_state <= evt_state_nxt;
        end
    end

endmodule : state_detect_multi

// File: tb/tb_state_detect_multi.sv
// Bench for state_detect_multi: table-driven decode vectors, directed corner
// sequences and randomized traffic, all against a run-length reference model.
module tb_state_detect_multi;

    localparam int unsigned N_CH       = 4;
    localparam int unsigned FILT_DEPTH = 8;
    localparam int unsigned CH_W       = 2;

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_ON   = 4'b1000;
    localparam logic [3:0] S_OFF  = 4'b0100;
    localparam logic [3:0] S_ERR  = 4'b0010;
    localparam logic [3:0] S_OPEN = 4'b0001;

    logic                clk_50MHz = 1'b0;
    logic                rst_n     = 1'b1;
    logic [N_CH-1:0]     result_on   = '0;
    logic [N_CH-1:0]     result_off  = '0;
    logic [N_CH-1:0]     result_err  = '0;
    logic [N_CH-1:0]     result_open = '0;
    logic [2*N_CH-1:0]   state;
    logic [N_CH-1:0]     state_valid;
    logic                evt_valid;
    logic                evt_ready   = 1'b0;
    logic [CH_W-1:0]     evt_ch;
    logic [1:0]          evt_state;
    logic [N_CH-1:0]     overrun;
    logic                clr_overrun = 1'b0;

    int checks = 0;
    int errors = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    state_detect_multi #(
        .N_CH       (N_CH),
        .FILT_DEPTH (FILT_DEPTH)
    ) dut (
        .clk_50MHz   (clk_50MHz),
        .rst_n       (rst_n),
        .result_on   (result_on),
        .result_off  (result_off),
        .result_err  (result_err),
        .result_open (result_open),
        .state       (state),
        .state_valid (state_valid),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .evt_state   (evt_state),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    // Reference model: length of the current run of identical samples per
    // channel, committed state, and a set of channels with undelivered changes.
    int         m_run_len  [N_CH];
    logic [1:0] m_run_code [N_CH];
    logic [1:0] m_state    [N_CH];
    bit         m_valid    [N_CH];
    bit         m_pend     [N_CH];
    bit         m_ovr      [N_CH];
    bit         m_evt_valid;
    int         m_evt_ch;
    logic [1:0] m_evt_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_run_len[i]  = 0;
            m_run_code[i] = 2'b00;
            m_state[i]    = 2'b00;
            m_valid[i]    = 1'b0;
            m_pend[i]     = 1'b0;
            m_ovr[i]      = 1'b0;
        end
        m_evt_valid = 1'b0;
        m_evt_ch    = 0;
        m_evt_state = 2'b00;
    endtask

    task automatic model_step();
        bit accepted;
        bit stalled;
        bit chg [N_CH];
        bit found;
        bit have;
        logic [1:0] code;
        accepted = m_evt_valid && evt_ready;
        stalled  = m_evt_valid && !evt_ready;
        for (int i = 0; i < N_CH; i++) begin
            have = 1'b1;
            code = 2'd0;
            if (result_on[i])        code = 2'd0;
            else if (result_off[i])  code = 2'd1;
            else if (result_err[i])  code = 2'd2;
            else if (result_open[i]) code = 2'd3;
            else                     have = 1'b0;
            if (!have) begin
                m_run_len[i] = 0;
            end else if (m_run_len[i] > 0 && code == m_run_code[i]) begin
                m_run_len[i]++;
            end else begin
                m_run_code[i] = code;
                m_run_len[i]  = 1;
            end
            chg[i] = 1'b0;
            if (m_run_len[i] >= FILT_DEPTH && (!m_valid[i] || m_state[i] != m_run_code[i])) begin
                m_state[i] = m_run_code[i];
                m_valid[i] = 1'b1;
                chg[i]     = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (chg[i] && m_pend[i]) m_ovr[i] = 1'b1;
            else if (clr_overrun)    m_ovr[i] = 1'b0;
            if (chg[i])                         m_pend[i] = 1'b1;
            else if (accepted && m_evt_ch == i) m_pend[i] = 1'b0;
        end
        m_evt_valid = 1'b0;
        foreach (m_pend[i]) if (m_pend[i]) m_evt_valid = 1'b1;
        if (!stalled) begin
            found    = 1'b0;
            m_evt_ch = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (!found && m_pend[i]) begin
                    m_evt_ch = i;
                    found    = 1'b1;
                end
            end
        end
        m_evt_state = m_state[m_evt_ch];
    endtask

    task automatic compare_all();
        logic [2*N_CH-1:0] es;
        logic [N_CH-1:0]   ev;
        logic [N_CH-1:0]   eo;
        for (int i = 0; i < N_CH; i++) begin
            es[2*i +: 2] = m_state[i];
            ev[i]        = m_valid[i];
            eo[i]        = m_ovr[i];
        end
        chk("model_state", 32'(state), 32'(es));
        chk("model_state_valid", 32'(state_valid), 32'(ev));
        chk("model_overrun", 32'(overrun), 32'(eo));
        chk("model_evt_valid", 32'(evt_valid), 32'(m_evt_valid));
        if (m_evt_valid) begin
            chk("model_evt_ch", 32'(evt_ch), 32'(m_evt_ch));
            chk("model_evt_state", 32'(evt_state), 32'(m_evt_state));
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_50MHz);
            if (rst_n) model_step();
            else       model_reset();
            #1;
            compare_all();
        end
    endtask

    task automatic set_ch(input int ch, input logic [3:0] s);
        result_on[ch]   = s[3];
        result_off[ch]  = s[2];
        result_err[ch]  = s[1];
        result_open[ch] = s[0];
    endtask

    task automatic clear_all();
        result_on   = '0;
        result_off  = '0;
        result_err  = '0;
        result_open = '0;
    endtask

    // Asserts reset between edges and checks outputs clear without a clock.
    task automatic do_reset();
        #4;
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_state_valid", 32'(state_valid), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_ch", 32'(evt_ch), 32'd0);
        chk("rst_evt_state", 32'(evt_state), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        model_reset();
        tick(2);
        #3;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] strb;
        logic [1:0] exp_st;
        bit         exp_evt;
    } vec_t;

    vec_t vecs [9];

    logic [3:0] pat [N_CH];

    initial begin
        vecs[0] = '{S_ON,                   2'b00, 1'b1};
        vecs[1] = '{S_OFF,                  2'b01, 1'b1};
        vecs[2] = '{S_OFF | S_OPEN,         2'b01, 1'b0};
        vecs[3] = '{S_ERR | S_OPEN,         2'b10, 1'b1};
        vecs[4] = '{S_OPEN,                 2'b11, 1'b1};
        vecs[5] = '{4'b1111,                2'b00, 1'b1};
        vecs[6] = '{S_OFF | S_ERR | S_OPEN, 2'b01, 1'b1};
        vecs[7] = '{S_ON | S_ERR,           2'b00, 1'b1};
        vecs[8] = '{S_ON,                   2'b00, 1'b0};

        model_reset();
        #5;
        do_reset();

        // Decode priority and commit/no-change on channel 0.
        foreach (vecs[v]) begin
            set_ch(0, vecs[v].strb);
            evt_ready = 1'b0;
            tick(FILT_DEPTH);
            chk("tbl_state", 32'(state[1:0]), 32'(vecs[v].exp_st));
            chk("tbl_evt_valid", 32'(evt_valid), 32'(vecs[v].exp_evt));
            if (vecs[v].exp_evt) chk("tbl_evt_state", 32'(evt_state), 32'(vecs[v].exp_st));
            clear_all();
            evt_ready = 1'b1;
            tick(1);
            evt_ready = 1'b0;
        end

        do_reset();

        // Error held exactly FILT_DEPTH cycles on channel 0.
        set_ch(0, S_ERR);
        tick(FILT_DEPTH - 1);
        chk("err_early_valid", 32'(state_valid[0]), 32'd0);
        tick(1);
        chk("err_state", 32'(state[1:0]), 32'b10);
        chk("err_state_valid", 32'(state_valid[0]), 32'd1);
        chk("err_evt_valid", 32'(evt_valid), 32'd1);
        chk("err_evt_ch", 32'(evt_ch), 32'd0);
        chk("err_evt_state", 32'(evt_state), 32'b10);
        clear_all();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("err_drained", 32'(evt_valid), 32'd0);

        // Interrupted run must not commit; a full run does.
        set_ch(1, S_ON);
        tick(FILT_DEPTH - 1);
        clear_all();
        tick(1);
        set_ch(1, S_ON);
        tick(FILT_DEPTH - 1);
        chk("gap_no_commit", 32'(state_valid[1]), 32'd0);
        clear_all();
        tick(1);
        set_ch(1, S_ON);
        tick(FILT_DEPTH);
        chk("gap_commit_valid", 32'(state_valid[1]), 32'd1);
        chk("gap_commit_state", 32'(state[3:2]), 32'b00);
        chk("gap_evt_ch", 32'(evt_ch), 32'd1);
        clear_all();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;

        // Priority on channel 2, then a short glitch that must stay silent.
        set_ch(2, S_ON | S_OPEN);
        tick(FILT_DEPTH);
        chk("prio_state", 32'(state[5:4]), 32'b00);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        set_ch(2, S_ERR);
        tick(3);
        set_ch(2, S_ON);
        tick(FILT_DEPTH + 2);
        chk("glitch_no_evt", 32'(evt_valid), 32'd0);
        chk("glitch_state", 32'(state[5:4]), 32'b00);
        clear_all();

        // Simultaneous commits on channels 0 and 3 under back-pressure.
        set_ch(0, S_OFF);
        set_ch(3, S_OPEN);
        tick(FILT_DEPTH);
        chk("dual_evt_valid", 32'(evt_valid), 32'd1);
        chk("dual_evt_ch", 32'(evt_ch), 32'd0);
        chk("dual_evt_state", 32'(evt_state), 32'b01);
        clear_all();
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("dual_hold_ch", 32'(evt_ch), 32'd0);
            chk("dual_hold_valid", 32'(evt_valid), 32'd1);
        end
        evt_ready = 1'b1;
        tick(1);
        chk("dual_second_valid", 32'(evt_valid), 32'd1);
        chk("dual_second_ch", 32'(evt_ch), 32'd3);
        chk("dual_second_state", 32'(evt_state), 32'b11);
        tick(1);
        chk("dual_drained", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;

        // Overrun: second commit on channel 1 before its event is taken.
        set_ch(1, S_OFF);
        tick(FILT_DEPTH);
        chk("ovr_first_state", 32'(evt_state), 32'b01);
        chk("ovr_first_flag", 32'(overrun[1]), 32'd0);
        set_ch(1, S_OPEN);
        tick(FILT_DEPTH);
        chk("ovr_flag", 32'(overrun[1]), 32'd1);
        chk("ovr_evt_ch", 32'(evt_ch), 32'd1);
        chk("ovr_evt_state", 32'(evt_state), 32'b11);
        clear_all();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("ovr_single_evt", 32'(evt_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun[1]), 32'd1);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        chk("ovr_cleared", 32'(overrun[1]), 32'd0);

        // Reset with an event pending and another channel mid-filter.
        set_ch(2, S_ERR);
        tick(FILT_DEPTH);
        chk("rst_pre_pending", 32'(evt_valid), 32'd1);
        clear_all();
        set_ch(0, S_ON);
        tick(4);
        clear_all();
        do_reset();
        tick(FILT_DEPTH + 4);
        chk("rst_no_replay", 32'(evt_valid), 32'd0);
        chk("rst_no_valid", 32'(state_valid), 32'd0);

        // Randomized traffic against the model, with one reset in the middle.
        foreach (pat[i]) pat[i] = S_NONE;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if ($urandom_range(0, 11) == 0) pat[ch] = 4'($urandom_range(0, 15));
                set_ch(ch, ($urandom_range(0, 29) == 0) ? S_NONE : pat[ch]);
            end
            evt_ready   = 1'($urandom_range(0, 1));
            clr_overrun = ($urandom_range(0, 39) == 0);
            if (c == 1500) do_reset();
            else           tick(1);
        end
        clear_all();
        evt_ready   = 1'b1;
        clr_overrun = 1'b0;
        tick(2 * N_CH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_state_detect_multi
